// File: rtl/wb_retire_buf.sv
// wb_retire_buf: DEPTH-entry in-order retire buffer between MEM and the register file / CP0.
// Optional WB_PERF_CNT_EN instantiates the retired / stall performance counters.
module wb_retire_buf #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WE_W   = 4,
  parameter int unsigned EXC_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic [DATA_W-1:0] ms_pc,
  input  logic [WE_W-1:0]   ms_gr_we,
  input  logic [4:0]        ms_dest,
  input  logic [DATA_W-1:0] ms_result,
  input  logic [EXC_W-1:0]  ms_exc,
  input  logic              ms_mfc0,
  input  logic              ms_mtc0,
  input  logic              ms_bd,
  input  logic [4:0]        ms_c0_addr,
  input  logic [DATA_W-1:0] ms_badvaddr,
  input  logic              flush,
  input  logic [4:0]        hz_raddr0,
  input  logic [4:0]        hz_raddr1,
  output logic              hz_hit0,
  output logic              hz_hit1,
  output logic [WE_W-1:0]   rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              c0_req,
  output logic [EXC_W+1:0]  c0_exception,
  output logic [4:0]        c0_addr,
  output logic [DATA_W-1:0] c0_wdata,
  output logic [DATA_W-1:0] c0_wb_pc,
  output logic [DATA_W-1:0] c0_badvaddr,
  output logic              c0_wb_bd,
  input  logic              c0_valid,
  input  logic [DATA_W-1:0] c0_res,
  output logic              ws_ex,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic [WE_W-1:0]   debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [WE_W-1:0]   gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] result;
    logic [EXC_W-1:0]  exc;
    logic              mfc0;
    logic              mtc0;
    logic              bd;
    logic [4:0]        c0_addr;
    logic [DATA_W-1:0] badvaddr;
  } entry_t;

  entry_t          entry_q [DEPTH];
  entry_t          head;
  entry_t          ms_entry;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            non_empty;
  logic            head_ready;
  logic            head_exc;
  logic            pop;
  logic            push;

  always_comb begin
    ms_entry          = '0;
    ms_entry.pc       = ms_pc;
    ms_entry.gr_we    = ms_gr_we;
    ms_entry.dest     = ms_dest;
    ms_entry.result   = ms_result;
    ms_entry.exc      = ms_exc;
    ms_entry.mfc0     = ms_mfc0;
    ms_entry.mtc0     = ms_mtc0;
    ms_entry.bd       = ms_bd;
    ms_entry.c0_addr  = ms_c0_addr;
    ms_entry.badvaddr = ms_badvaddr;
  end

  assign non_empty  = count_q != '0;
  assign head       = entry_q[rd_ptr_q];
  assign head_exc   = |head.exc;
  // An MFC0 head holds until CP0 answers.
  assign head_ready = non_empty && (!head.mfc0 || c0_valid);
  assign pop        = head_ready && !reset;
  assign ws_ex      = pop && head_exc;
  assign ws_allowin = count_q != CntW'(DEPTH);
  assign push       = ms_to_ws_valid && ws_allowin && !flush && !ws_ex;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush || ws_ex) begin
      // Drop everything younger; the write pointer stays put.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) entry_q[wr_ptr_q] <= ms_entry;
  end

  always_comb begin
    rf_we       = '0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    debug_wb_pc = '0;
    if (pop) begin
      rf_we       = head_exc ? '0 : head.gr_we;
      rf_waddr    = head.dest;
      rf_wdata    = head.mfc0 ? c0_res : head.result;
      debug_wb_pc = head.pc;
    end
  end

  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  always_comb begin
    c0_req       = 1'b0;
    c0_exception = '0;
    c0_addr      = '0;
    c0_wdata     = '0;
    c0_wb_pc     = '0;
    c0_badvaddr  = '0;
    c0_wb_bd     = 1'b0;
    if (non_empty) begin
      c0_req       = head_exc || head.mfc0 || head.mtc0;
      c0_exception = {head.exc, head.mfc0, head.mtc0};
      c0_addr      = head.c0_addr;
      c0_wdata     = head.result;
      c0_wb_pc     = head.pc;
      c0_badvaddr  = head.badvaddr;
      c0_wb_bd     = head.bd;
    end
  end

  // Walk entries oldest-first from rd_ptr; only the first count_q slots are live.
  always_comb begin
    hz_hit0 = 1'b0;
    hz_hit1 = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      automatic logic [PtrW-1:0] idx = rd_ptr_q + PtrW'(k);
      if ((CntW'(k) < count_q) && (|entry_q[idx].gr_we)) begin
        if (hz_raddr0 != 5'd0 && entry_q[idx].dest == hz_raddr0) hz_hit0 = 1'b1;
        if (hz_raddr1 != 5'd0 && entry_q[idx].dest == hz_raddr1) hz_hit1 = 1'b1;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_retired_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop)                      perf_retired_q <= perf_retired_q + 32'd1;
      if (non_empty && !head_ready) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`else
  assign perf_retired = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: doc/wb_retire_buf.md
# wb_retire_buf

Parametrised write-back stage with a DEPTH-entry in-order retire buffer between the MEM stage and the register file / CP0. It accepts one instruction per cycle from MEM, retires at most one per cycle in program order, and stalls the head entry on MFC0 until CP0 returns data. It also squashes younger entries when an exception or ERET retires, and answers register-hazard queries against every in-flight entry.

## Interface
Parameters:
- DEPTH, 2, number of buffer entries; power of two, ≥2
- DATA_W, 32, result / PC / badvaddr width
- WE_W, 4, byte write-enable width
- EXC_W, 8, exception-cause vector width; bit EXC_W-1 is ERET

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- ms_to_ws_valid  in  1  MEM holds a valid instruction
- ws_allowin  out  1  buffer can accept; = (count != DEPTH)
- ms_pc  in  DATA_W  instruction PC
- ms_gr_we  in  WE_W  GPR byte enables
- ms_dest  in  5  GPR destination
- ms_result  in  DATA_W  result; also MTC0 write data
- ms_exc  in  EXC_W  exception causes, one-hot or zero
- ms_mfc0, ms_mtc0, ms_bd  in  1 each  MFC0 / MTC0 / in-delay-slot
- ms_c0_addr  in  5  CP0 register number
- ms_badvaddr  in  DATA_W  faulting address
- flush  in  1  external pipeline flush
- hz_raddr0, hz_raddr1  in  5 each  hazard query addresses
- hz_hit0, hz_hit1  out  1 each  a valid entry has gr_we≠0, dest==addr, addr≠0
- rf_we  out  WE_W; rf_waddr  out  5; rf_wdata  out  DATA_W  GPR write port
- c0_req  out  1  head is exception/ERET/MFC0/MTC0
- c0_exception  out  EXC_W+2  {head exc, mfc0, mtc0}
- c0_addr  out  5; c0_wdata, c0_wb_pc, c0_badvaddr  out  DATA_W; c0_wb_bd  out  1
- c0_valid  in  1; c0_res  in  DATA_W  CP0 read response
- ws_ex  out  1  head retires with exception or ERET this cycle
- debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata  out  trace of retiring entry
- perf_retired, perf_stall  out  32 each  performance counters

## Operation
- Circular buffer: wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits).
- Push: ms_to_ws_valid && ws_allowin && !flush && !ws_ex. Writes all ms_* fields at wr_ptr.
- head_ready = count≠0 && (!head.mfc0 || c0_valid). Pop = head_ready.
- On pop: rf_we = head.gr_we when head exc==0, else 0. rf_waddr = head.dest. rf_wdata = c0_res if head.mfc0, else head.result.
- ws_ex = pop && |head.exc. When ws_ex: pop the head and clear all other entries (count←0, rd_ptr←wr_ptr). A same-cycle push is dropped.
- flush: count←0, rd_ptr←wr_ptr. Flush takes priority over push and pop, but the head's combinational outputs in that cycle are still driven.
- c0_* outputs show the head fields whenever count≠0. They are zero when empty.
- Hazard check: combinational over all valid entries, independent of head_ready.
- Push and pop in the same cycle leave count unchanged.

## Timing
- Reset: count, pointers and perf counters ←0. Every output is 0 except ws_allowin=1.
- Latency: an entry accepted at edge N is at the head and writes the RF during cycle N+1 when the buffer was empty. This matches a single-register write-back stage.
- MFC0 head: rf_we=0 until the cycle c0_valid=1. It retires that cycle with rf_wdata=c0_res.
- ws_allowin depends only on count. There is no combinational path from c0_valid or flush.
- Full: ws_allowin=0 even if a pop happens in the same cycle.
- Reset mid-stall: all entries are discarded and no rf write occurs.

## Configuration
- WB_PERF_CNT_EN defined: perf_retired increments on every pop. perf_stall increments each cycle with count≠0 && !head_ready. Both wrap at 2^32 and are cleared by reset only.
- WB_PERF_CNT_EN undefined: counters are not instantiated and perf_retired = perf_stall = 0.

## Test plan
- Single push of ADDU (pc 0xBFC00000, we 0xF, dest 5, result 0x1234), DEPTH=2 → rf_we=0xF, rf_waddr=5, rf_wdata=0x1234 the next cycle. ws_allowin stays 1.
- MFC0 head with c0_valid held 0 for 3 cycles, then 1 with c0_res=0xDEAD → rf_we=0 for 3 cycles, then 0xF with data 0xDEAD. Following pushes fill to full and ws_allowin=0. With WB_PERF_CNT_EN, perf_stall=3.
- Head with exc bit0 set and one younger entry queued → ws_ex=1 and rf_we=0 that cycle. Next cycle count=0 and the younger entry is never written.
- flush asserted together with ms_to_ws_valid while 2 entries are queued → next cycle count=0, no rf writes, ws_allowin=1.
- Entry with dest 7, we 0xF queued behind a stalled MFC0 → hz_raddr0=7 gives hz_hit0=1. dest 0 or we 0 gives hz_hit0=0.
- 10 back-to-back pushes with continuous pops → 10 writes in order and pointers wrap cleanly. With WB_PERF_CNT_EN, perf_retired=10.
